// File: rtl/chip8_reg_mem_xfer.sv
// Sequencer for Chip-8 FX55/FX65: moves V0..VX between the register file
// (port 1) and main memory at I, one byte per cycle.
module chip8_reg_mem_xfer #(
  parameter int MEM_RD_LAT = 2
) (
  input  logic        cpu_clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        dir,
  input  logic [3:0]  last_reg,
  input  logic [11:0] base_addr,
  output logic        busy,
  output logic        done,
  output logic [11:0] i_next,
  output logic [3:0]  reg_addr,
  output logic        reg_we,
  output logic [7:0]  reg_wdata,
  input  logic [7:0]  reg_rdata,
  output logic [11:0] mem_addr,
  output logic        mem_we,
  output logic        mem_re,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [2:0] {IDLE, STORE, LOAD, DRAIN, DONE} state_t;

  state_t      state;
  logic [3:0]  k;
  logic [3:0]  last_q;
  logic [11:0] base_q;
  logic [11:0] k_addr;
  logic [11:0] end_addr;

  // Valid/index delay line lining each issued read up with its returning data.
  logic [MEM_RD_LAT-1:0] dl_valid;
  logic [3:0]            dl_idx [MEM_RD_LAT];

  logic       wb_valid;
  logic [3:0] wb_idx;
  logic       wb_active;

  assign k_addr    = base_q + {8'd0, k};
  assign end_addr  = base_q + {8'd0, last_q} + 12'd1;
  assign wb_valid  = dl_valid[MEM_RD_LAT-1];
  assign wb_idx    = dl_idx[MEM_RD_LAT-1];
  assign wb_active = wb_valid && (state == LOAD || state == DRAIN);

  always_ff @(posedge cpu_clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      k        <= 4'd0;
      last_q   <= 4'd0;
      base_q   <= 12'd0;
      i_next   <= 12'd0;
      dl_valid <= '0;
      for (int i = 0; i < MEM_RD_LAT; i++) dl_idx[i] <= 4'd0;
    end else begin
      dl_valid[0] <= (state == LOAD);
      dl_idx[0]   <= k;
      for (int i = 1; i < MEM_RD_LAT; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_idx[i]   <= dl_idx[i-1];
      end

      case (state)
        IDLE: begin
          if (start) begin
            last_q <= last_reg;
            base_q <= base_addr;
            k      <= 4'd0;
            state  <= dir ? LOAD : STORE;
          end
        end
        STORE: begin
          if (k == last_q) begin
            state  <= DONE;
            i_next <= end_addr;
          end else begin
            k <= k + 4'd1;
          end
        end
        LOAD: begin
          if (k == last_q) state <= DRAIN;
          else k <= k + 4'd1;
        end
        DRAIN: begin
          // Index X is always the final write-back, and it lands in DRAIN.
          if (wb_valid && wb_idx == last_q) begin
            state  <= DONE;
            i_next <= end_addr;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state == STORE) || (state == LOAD) || (state == DRAIN);
    done      = (state == DONE);
    reg_addr  = 4'd0;
    reg_we    = 1'b0;
    reg_wdata = 8'd0;
    mem_addr  = 12'd0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = 8'd0;
    if (state == STORE) begin
      reg_addr  = k;
      mem_addr  = k_addr;
      mem_wdata = reg_rdata;
      mem_we    = 1'b1;
    end
    if (state == LOAD) begin
      mem_re   = 1'b1;
      mem_addr = k_addr;
    end
    if (wb_active) begin
      reg_we    = 1'b1;
      reg_addr  = wb_idx;
      reg_wdata = mem_rdata;
    end
  end

endmodule

// File: tb/tb_chip8_reg_mem_xfer.sv
// Self-checking bench for chip8_reg_mem_xfer: directed vector table on two
// instances (read latency 2 and 1) plus hand-written start-ignore and reset sequences.
module tb_chip8_reg_mem_xfer;

  logic cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  logic        reset_n, start, dir, use1;
  logic [3:0]  last_reg;
  logic [11:0] base_addr;
  logic        start_a, start_b;
  assign start_a = start & ~use1;
  assign start_b = start & use1;

  logic        busy_a, done_a, reg_we_a, mem_we_a, mem_re_a;
  logic [11:0] i_next_a, mem_addr_a;
  logic [3:0]  reg_addr_a;
  logic [7:0]  reg_wdata_a, reg_rdata_a, mem_wdata_a, mem_rdata_a;
  logic        busy_b, done_b, reg_we_b, mem_we_b, mem_re_b;
  logic [11:0] i_next_b, mem_addr_b;
  logic [3:0]  reg_addr_b;
  logic [7:0]  reg_wdata_b, reg_rdata_b, mem_wdata_b, mem_rdata_b;

  chip8_reg_mem_xfer #(.MEM_RD_LAT(2)) dut_a (
    .cpu_clk(cpu_clk), .reset_n(reset_n), .start(start_a), .dir(dir),
    .last_reg(last_reg), .base_addr(base_addr), .busy(busy_a), .done(done_a),
    .i_next(i_next_a), .reg_addr(reg_addr_a), .reg_we(reg_we_a),
    .reg_wdata(reg_wdata_a), .reg_rdata(reg_rdata_a), .mem_addr(mem_addr_a),
    .mem_we(mem_we_a), .mem_re(mem_re_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a));

  chip8_reg_mem_xfer #(.MEM_RD_LAT(1)) dut_b (
    .cpu_clk(cpu_clk), .reset_n(reset_n), .start(start_b), .dir(dir),
    .last_reg(last_reg), .base_addr(base_addr), .busy(busy_b), .done(done_b),
    .i_next(i_next_b), .reg_addr(reg_addr_b), .reg_we(reg_we_b),
    .reg_wdata(reg_wdata_b), .reg_rdata(reg_rdata_b), .mem_addr(mem_addr_b),
    .mem_we(mem_we_b), .mem_re(mem_re_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b));

  // Register file and memory models; the preload port lets the bench seed contents.
  logic        pre_we;
  logic [3:0]  pre_raddr;
  logic [11:0] pre_maddr;
  logic [7:0]  pre_rdata, pre_mdata;
  logic [7:0]  regs_a [16];
  logic [7:0]  regs_b [16];
  logic [7:0]  mem_a [4096];
  logic [7:0]  mem_b [4096];
  logic [7:0]  pipe_a0, pipe_a1, pipe_b0;

  always @(posedge cpu_clk) begin
    if (pre_we) begin
      regs_a[pre_raddr] <= pre_rdata;
      regs_b[pre_raddr] <= pre_rdata;
      mem_a[pre_maddr]  <= pre_mdata;
      mem_b[pre_maddr]  <= pre_mdata;
    end else begin
      if (reg_we_a) regs_a[reg_addr_a] <= reg_wdata_a;
      if (reg_we_b) regs_b[reg_addr_b] <= reg_wdata_b;
      if (mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
      if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
    end
    pipe_a0 <= mem_re_a ? mem_a[mem_addr_a] : 8'h00;
    pipe_a1 <= pipe_a0;
    pipe_b0 <= mem_re_b ? mem_b[mem_addr_b] : 8'h00;
  end

  assign reg_rdata_a = regs_a[reg_addr_a];
  assign reg_rdata_b = regs_b[reg_addr_b];
  assign mem_rdata_a = pipe_a1;
  assign mem_rdata_b = pipe_b0;

  logic        s_busy, s_done, s_reg_we, s_mem_we, s_mem_re;
  logic [11:0] s_inext;
  assign s_busy   = use1 ? busy_b   : busy_a;
  assign s_done   = use1 ? done_b   : done_a;
  assign s_reg_we = use1 ? reg_we_b : reg_we_a;
  assign s_mem_we = use1 ? mem_we_b : mem_we_a;
  assign s_mem_re = use1 ? mem_re_b : mem_re_a;
  assign s_inext  = use1 ? i_next_b : i_next_a;

  typedef struct {
    logic        d;
    logic        l1;
    logic [3:0]  x;
    logic [11:0] base;
    int          busy_n;
    int          done_cyc;
    int          first_wb;
    logic [11:0] inext;
  } vec_t;

  vec_t vecs [6];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [7:0] rpat(input int k);
    return 8'((k + 1) * 17);
  endfunction

  function automatic logic [7:0] mpat(input int k);
    return 8'(8'hA1 + k * 17);
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  task automatic setup(input logic d, input logic [11:0] base);
    for (int k = 0; k < 16; k++) begin
      @(negedge cpu_clk);
      pre_we    = 1'b1;
      pre_raddr = 4'(k);
      pre_rdata = d ? 8'hEE : rpat(k);
      pre_maddr = base + 12'(k);
      pre_mdata = d ? mpat(k) : 8'hEE;
    end
    @(negedge cpu_clk);
    pre_we = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    int busy_n, done_n, got_cyc, overlap, mw, rw, mr, first, cyc;
    logic [11:0] got_inext, a;
    logic [7:0]  got;
    string       p;
    p = $sformatf("v%0d_", idx);
    use1 = v.l1;
    setup(v.d, v.base);
    @(negedge cpu_clk);
    start = 1'b1; dir = v.d; last_reg = v.x; base_addr = v.base;
    @(negedge cpu_clk);
    start = 1'b0;
    busy_n = 0; done_n = 0; got_cyc = 0; overlap = 0;
    mw = 0; rw = 0; mr = 0; first = 0; got_inext = 12'd0;
    cyc = 1;
    while (cyc <= 40) begin
      if (s_busy) busy_n++;
      if (s_busy && s_done) overlap++;
      if (s_done) begin
        done_n++;
        if (got_cyc == 0) begin got_cyc = cyc; got_inext = s_inext; end
      end
      if (s_mem_we) mw++;
      if (s_mem_re) mr++;
      if (s_reg_we) begin
        rw++;
        if (first == 0) first = cyc;
      end
      if (got_cyc != 0 && cyc > got_cyc) break;
      @(negedge cpu_clk);
      cyc++;
    end
    check_output({p, "busy_cycles"}, busy_n, v.busy_n);
    check_output({p, "done_cycle"}, got_cyc, v.done_cyc);
    check_output({p, "done_width"}, done_n, 1);
    check_output({p, "busy_done_overlap"}, overlap, 0);
    check_output({p, "i_next"}, int'(got_inext), int'(v.inext));
    check_output({p, "i_next_hold"}, int'(s_inext), int'(v.inext));
    if (!v.d) begin
      check_output({p, "mem_we_count"}, mw, int'(v.x) + 1);
      check_output({p, "reg_we_count"}, rw, 0);
      check_output({p, "mem_re_count"}, mr, 0);
    end else begin
      check_output({p, "reg_we_count"}, rw, int'(v.x) + 1);
      check_output({p, "mem_re_count"}, mr, int'(v.x) + 1);
      check_output({p, "mem_we_count"}, mw, 0);
      check_output({p, "first_writeback"}, first, v.first_wb);
    end
    for (int k = 0; k <= int'(v.x) + 1 && k < 16; k++) begin
      a = v.base + 12'(k);
      if (!v.d) got = v.l1 ? mem_b[a] : mem_a[a];
      else      got = v.l1 ? regs_b[k] : regs_a[k];
      if (k <= int'(v.x))
        check_output($sformatf("%sdata_%0d", p, k), int'(got), int'(v.d ? mpat(k) : rpat(k)));
      else
        check_output($sformatf("%sbeyond_%0d", p, k), int'(got), 8'hEE);
    end
  endtask

  initial begin
    int mw, strobes, waited;
    vecs[0] = '{1'b0, 1'b0, 4'd3,  12'h300, 4,  5,  0, 12'h304};
    vecs[1] = '{1'b1, 1'b0, 4'd2,  12'h200, 5,  6,  3, 12'h203};
    vecs[2] = '{1'b1, 1'b1, 4'd2,  12'h200, 4,  5,  2, 12'h203};
    vecs[3] = '{1'b0, 1'b0, 4'd15, 12'hFF8, 16, 17, 0, 12'h008};
    vecs[4] = '{1'b1, 1'b0, 4'd0,  12'h123, 3,  4,  3, 12'h124};
    vecs[5] = '{1'b1, 1'b0, 4'd15, 12'hFFE, 18, 19, 3, 12'h00E};

    reset_n = 1'b0; start = 1'b0; dir = 1'b0; use1 = 1'b0;
    last_reg = 4'd0; base_addr = 12'd0;
    pre_we = 1'b0; pre_raddr = 4'd0; pre_maddr = 12'd0;
    pre_rdata = 8'd0; pre_mdata = 8'd0;
    repeat (3) @(negedge cpu_clk);
    check_output("rst_busy", int'(busy_a), 0);
    check_output("rst_done", int'(done_a), 0);
    check_output("rst_i_next", int'(i_next_a), 0);
    check_output("rst_strobes", int'({reg_we_a, mem_we_a, mem_re_a}), 0);
    check_output("rst_addrs", int'({reg_addr_a, mem_addr_a}), 0);
    check_output("rst_data", int'({reg_wdata_a, mem_wdata_a}), 0);
    check_output("rst_b_busy", int'(busy_b), 0);
    reset_n = 1'b1;
    @(negedge cpu_clk);

    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i], i);

    // Starts during busy and during DONE must be ignored; the one after DONE is taken.
    use1 = 1'b0;
    setup(1'b0, 12'h300);
    @(negedge cpu_clk);
    start = 1'b1; dir = 1'b0; last_reg = 4'd3; base_addr = 12'h300;
    @(negedge cpu_clk);
    mw = 0;
    for (int c = 1; c <= 7; c++) begin
      if (c <= 6 && mem_we_a) mw++;
      if (c == 5) check_output("ign_done_cycle", int'(done_a), 1);
      if (c == 6) begin
        check_output("ign_idle_busy", int'(busy_a), 0);
        check_output("ign_idle_done", int'(done_a), 0);
      end
      if (c == 7) check_output("restart_busy", int'(busy_a), 1);
      start = (c == 2 || c == 5 || c == 6);
      @(negedge cpu_clk);
    end
    check_output("ign_mem_we_count", mw, 4);
    waited = 0;
    while (!done_a && waited < 20) begin
      @(negedge cpu_clk);
      waited++;
    end
    check_output("restart_done_seen", int'(done_a), 1);
    check_output("restart_i_next", int'(i_next_a), 12'h304);
    @(negedge cpu_clk);

    // Reset after two load issues drops the in-flight reads.
    setup(1'b1, 12'h400);
    @(negedge cpu_clk);
    start = 1'b1; dir = 1'b1; last_reg = 4'd5; base_addr = 12'h400;
    @(negedge cpu_clk);
    start = 1'b0;
    check_output("mid_issue0", int'(mem_re_a), 1);
    @(negedge cpu_clk);
    check_output("mid_issue1", int'(mem_re_a), 1);
    reset_n = 1'b0;
    @(negedge cpu_clk);
    check_output("mid_rst_busy", int'(busy_a), 0);
    check_output("mid_rst_strobes", int'({reg_we_a, mem_we_a, mem_re_a, done_a}), 0);
    check_output("mid_rst_i_next", int'(i_next_a), 0);
    reset_n = 1'b1;
    strobes = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge cpu_clk);
      if (reg_we_a || mem_we_a || mem_re_a || busy_a) strobes++;
    end
    check_output("mid_post_strobes", strobes, 0);
    check_output("mid_v0_kept", int'(regs_a[0]), 8'hEE);
    check_output("mid_v1_kept", int'(regs_a[1]), 8'hEE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
